// File: rtl/posit_mul_arbiter_if.sv
// Requester-side and multiplier-side bus of the shared posit multiplier arbiter.
// The arbiter connects through the slave modport; the environment (requesters
// plus multiplier) uses the master modport.
interface posit_mul_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_result;
    logic               rsp_err;
    logic               mul_start;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [31:0]        mul_result;
    logic               mul_done;
    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, mul_done,
        output req_ready, rsp_valid, rsp_result, rsp_err,
               mul_start, mul_a, mul_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, mul_done,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
               mul_start, mul_a, mul_b, busy
    );
endinterface

// File: rtl/posit_mul_arbiter.sv
// Round-robin arbiter sharing one posit multiplier among NREQ requesters,
// with a watchdog that answers NaR plus an error flag if the multiplier hangs.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | searching for a requester from r_ptr upward; grant is combinational
//  S_ISSUE | operands latched, mul_start high for this single cycle
//  S_WAIT  | waiting for a rising edge of mul_done or watchdog expiry
//  S_RESP  | rsp_valid pulse to the owner, pointer moves past the owner
module posit_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    posit_mul_arbiter_if.slave  io_bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [TMR_W-1:0]   r_timer;
    logic               r_done_q;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [31:0]        r_rsp_result;
    logic               r_rsp_err;
    logic               r_mul_start;
    logic [NREQ-1:0]    r_rsp_valid;
    logic               r_busy;

    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_cand;
    logic               w_any_valid;
    logic               w_done_evt;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [NREQ-1:0]    w_owner_onehot;

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_winner    = r_ptr;
        w_cand      = '0;
        w_any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_any_valid && io_bus.req_valid[w_cand]) begin
                w_any_valid = 1'b1;
                w_winner    = w_cand;
            end
        end
    end

    // A done level left over from an earlier op must not count, only a fresh rise.
    assign w_done_evt     = io_bus.mul_done & ~r_done_q;
    assign w_ptr_next     = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_owner_onehot = ONE << r_owner;

    assign io_bus.req_ready  = (r_state == S_IDLE && w_any_valid) ? (ONE << w_winner) : '0;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.rsp_result = r_rsp_result;
    assign io_bus.rsp_err    = r_rsp_err;
    assign io_bus.mul_start  = r_mul_start;
    assign io_bus.mul_a      = r_mul_a;
    assign io_bus.mul_b      = r_mul_b;
    assign io_bus.busy       = r_busy;

    // Sequencer: grant, issue, wait with watchdog, respond; outputs registered alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_timer      <= '0;
            r_done_q     <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_mul_start  <= 1'b0;
            r_rsp_valid  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_done_q <= io_bus.mul_done;
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_mul_a     <= io_bus.req_a[32*w_winner +: 32];
                        r_mul_b     <= io_bus.req_b[32*w_winner +: 32];
                        r_owner     <= w_winner;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mul_start <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_done_evt) begin
                        r_rsp_result <= io_bus.mul_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= w_owner_onehot;
                        r_state      <= S_RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_rsp_result <= 32'h8000_0000;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= w_owner_onehot;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_ptr       <= w_ptr_next;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Bench for posit_mul_arbiter: the bench plays requesters and a fake multiplier
// whose result ramps every cycle, so the captured value pins the capture cycle.
module tb_posit_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    posit_mul_arbiter_if #(.NREQ(NREQ)) bus ();

    posit_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first valid index scanning ptr, ptr+1, ... modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (v[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    // Fake multiplier done waveform, cycle c counted from the mul_start cycle.
    function automatic logic done_at(input int c, input int lat, input bit level, input bit pre_hold);
        logic d;
        d = level ? (c >= lat) : (c == lat);
        if (pre_hold && c < lat - 1) d = 1'b1;
        return d;
    endfunction

    // One transaction; entered and left just after a negedge with the DUT idle.
    task automatic run_op(input logic [NREQ-1:0] valid, input int lat, input bit level,
                          input bit pre_hold, input bit keep, input logic [31:0] res_base,
                          input bit use_fix, input logic [31:0] fix_a, input logic [31:0] fix_b,
                          input string tag, output int granted);
        logic [31:0] a [NREQ];
        logic [31:0] b [NREQ];
        int          w, exp_resp, last;
        bit          exp_err, bad_rsp, bad_rdy, bad_start, bad_busy;
        logic [31:0] exp_res;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = use_fix ? fix_a : $urandom;
            b[i] = use_fix ? fix_b : $urandom;
            bus.req_a[32*i +: 32] = a[i];
            bus.req_b[32*i +: 32] = b[i];
        end
        bus.req_valid  = valid;
        bus.mul_result = res_base;
        if (pre_hold) bus.mul_done = 1'b1;
        w       = rr_pick(valid, m_ptr);
        granted = w;
        exp_err  = !(lat >= 1 && lat <= TIMEOUT);
        exp_resp = exp_err ? TIMEOUT + 1 : lat + 1;
        exp_res  = exp_err ? 32'h8000_0000 : res_base + 32'(lat);
        last     = keep ? exp_resp + 1 : exp_resp + 3;
        bad_rsp = 0; bad_rdy = 0; bad_start = 0; bad_busy = 0;
        #1;
        check_eq({tag, "/grant"}, 32'(bus.req_ready), 32'(1) << w);
        @(posedge clk);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_eq({tag, "/start"}, 32'(bus.mul_start), 32'd1);
                check_eq({tag, "/mul_a"}, bus.mul_a, a[w]);
                check_eq({tag, "/mul_b"}, bus.mul_b, b[w]);
            end else if (bus.mul_start !== 1'b0) begin
                bad_start = 1;
            end
            if (c == exp_resp) begin
                check_eq({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << w);
                check_eq({tag, "/rsp_result"}, bus.rsp_result, exp_res);
                check_eq({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
                check_eq({tag, "/mul_a_stable"}, bus.mul_a, a[w]);
            end else if (bus.rsp_valid !== '0) begin
                bad_rsp = 1;
            end
            if (c == exp_resp + 1)
                check_eq({tag, "/result_hold"}, bus.rsp_result, exp_res);
            if (c <= exp_resp && bus.req_ready !== '0) bad_rdy = 1;
            if (bus.busy !== (c <= exp_resp)) bad_busy = 1;
            bus.mul_done   = done_at(c, lat, level, pre_hold);
            bus.mul_result = res_base + 32'(c);
            if (c == exp_resp && !keep) bus.req_valid = '0;
        end
        check_eq({tag, "/extra_rsp"}, 32'(bad_rsp), 32'd0);
        check_eq({tag, "/ready_busy"}, 32'(bad_rdy), 32'd0);
        check_eq({tag, "/extra_start"}, 32'(bad_start), 32'd0);
        check_eq({tag, "/busy"}, 32'(bad_busy), 32'd0);
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "/busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "/mul_start"}, 32'(bus.mul_start), 32'd0);
        check_eq({tag, "/mul_a"}, bus.mul_a, 32'd0);
        check_eq({tag, "/mul_b"}, bus.mul_b, 32'd0);
        check_eq({tag, "/rsp_result"}, bus.rsp_result, 32'd0);
        check_eq({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check_eq({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, "/req_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    initial begin
        int g, lat;
        bit keep, level, pre;
        logic [NREQ-1:0] v;
        bit bad;

        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.mul_result = '0;
        bus.mul_done   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // single request, multiplier answers 1.0 * x = x
        run_op(4'b0100, 3, 0, 0, 0, 32'h4800_0000 - 32'd3, 1, 32'h4000_0000, 32'h4800_0000, "single", g);

        // move pointer to 0, then full load: grants 0,1,2,3,0
        run_op(4'b1000, 2, 0, 0, 0, $urandom, 0, 0, 0, "align", g);
        for (int i = 0; i < 5; i++) begin
            run_op(4'hF, $urandom_range(1, 6), 0, 0, 1, $urandom, 0, 0, 0, "fullload", g);
            check_eq("fullload/order", 32'(g), 32'(i % NREQ));
        end

        run_op(4'b0010, 100, 0, 0, 0, $urandom, 0, 0, 0, "stuck", g);
        run_op(4'b0001, 6, 1, 1, 0, $urandom, 0, 0, 0, "held_done", g);
        run_op(4'b1010, TIMEOUT, 0, 0, 0, $urandom, 0, 0, 0, "done_at_timeout", g);
        run_op(4'b0110, 0, 0, 0, 0, $urandom, 0, 0, 0, "done_in_issue", g);
        run_op(4'b1001, TIMEOUT + 1, 0, 0, 0, $urandom, 0, 0, 0, "late_done", g);

        for (int i = 0; i < 40; i++) begin
            v     = 4'($urandom_range(1, 15));
            keep  = 1'($urandom_range(0, 1));
            level = 1'($urandom_range(0, 1));
            lat   = keep ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, TIMEOUT + 4);
            pre   = (lat >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(v, lat, level, pre, keep, $urandom, 0, 0, 0, "random", g);
        end

        // reset during WAIT after moving the pointer away from 0
        run_op(4'b0001, 3, 0, 0, 0, $urandom, 0, 0, 0, "pre_reset", g);
        bus.mul_done  = 1'b0;
        bus.req_valid = 4'b0100;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst          = 1'b0;
        bus.mul_done = 1'b1;
        @(negedge clk);
        bus.mul_done = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) bad = 1;
        end
        check_eq("post_reset/quiet", 32'(bad), 32'd0);
        m_ptr = 0;
        run_op(4'hF, 4, 0, 0, 0, $urandom, 0, 0, 0, "post_reset", g);
        check_eq("post_reset/first_grant", 32'(g), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
